ahb_data_master: RTL and testbench
==================================

AHB_DATA_MASTER -- requirements
Module: ahb_data_master

Interface
REQ-001 Parameter ROM_BASE, default 32'h0000_0000, base of instruction-memory region (HSEL1).
REQ-002 Parameter RAM_BASE, default 32'h1000_0000, base of data-memory region (HSEL2).
REQ-003 Parameter REGION_BITS, default 16, log2 of each region's byte size.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, wait-state limit (used only with the Configuration macro).
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core request present
- req_ready  out  1  request accepted this cycle
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_write  in  1  1 = store
- req_size  in  3  0 = byte, 1 = half, 2 = word
- req_signed  in  1  sign-extend load
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  load/fetch data
- resp_err  out  1  error response
- HSEL1, HSEL2  out  1 each  slave selects
- haddr, hwdata  out  32 each  AHB address and write data
- hwrite  out  1  AHB write flag
- hsize  out  3  AHB size
- hprot  out  4  AHB protection, constant 4'b0011
- htrans  out  2  IDLE = 0, NONSEQ = 2
- is_signed  out  1  load sign flag
- instruction, load_out  in  32 each  slave read data
- hready_inst, hready_data, hresp_inst, hresp_data  in  1 each  slave handshakes

Function
REQ-006 FSM states: IDLE, ADDR, DATA, ERR, RESP.
REQ-007 IDLE: req_ready = 1. On req_valid, latch the request and decode it: legal → ADDR; illegal → ERR.
REQ-008 Decode: req_addr[31:REGION_BITS] matching ROM_BASE selects ROM; matching RAM_BASE selects RAM; any other address is illegal.
REQ-009 Also illegal: req_size > 2; halfword with addr[0] = 1; word with addr[1:0] ≠ 0; any write to ROM.
REQ-010 ADDR (exactly one cycle): htrans = NONSEQ; drive haddr, hwrite, hsize and is_signed from the latch; assert only the selected HSEL.
REQ-011 DATA: htrans = IDLE; HSEL, haddr and hwrite held; hwdata = latched wdata. The selected slave's hready and hresp are used; the other slave's are ignored.
REQ-012 DATA with hready = 0: stay in DATA.
REQ-013 DATA with hready = 1: capture the selected slave's data (instruction for ROM, load_out for RAM), capture resp_err = hresp, go to RESP.
REQ-014 RESP (one cycle): resp_valid = 1 with resp_rdata and resp_err; next state IDLE. resp_rdata = 0 for writes.
REQ-015 ERR (one cycle): no HSEL asserted, htrans = IDLE; resp_valid = 1, resp_err = 1, resp_rdata = 0; next state IDLE.
REQ-016 req_ready = 0 outside IDLE; req_valid outside IDLE is ignored and the core holds it.
REQ-017 Legal transfer latency: acceptance edge N; ADDR cycle N+1; DATA cycle N+2 (zero wait); resp_valid in cycle N+3, plus one cycle per wait state.
REQ-018 Outside ADDR and DATA: HSEL1 = HSEL2 = 0 and htrans = IDLE. HSEL1 and HSEL2 are never asserted together.

Reset
REQ-019 reset low immediately forces IDLE, regardless of clk and mid-transfer.
REQ-020 During reset, all outputs are 0 except hprot = 4'b0011 and req_ready = 0.
REQ-021 req_ready = 1 from the first clk edge after reset deasserts.
REQ-022 An in-flight transfer is dropped by reset, with no resp_valid.

Configuration
REQ-023 Macro AHB_MASTER_TIMEOUT_EN defined: a wait counter clears on entry to DATA and increments each cycle hready = 0. When the count reaches TIMEOUT_CYCLES, next state is RESP with resp_err = 1 and resp_rdata = 0.
REQ-024 Macro undefined: no counter logic; DATA waits indefinitely.

Structure
REQ-025 Package ahb_pkg holds: state enum, htrans encodings, hsize encodings, the HPROT_DATA constant, and default ROM_BASE/RAM_BASE.
REQ-026 One sub-module, ahb_addr_decode, is combinational: inputs address, size, write; outputs sel_rom, sel_ram, illegal.

Verification
REQ-027 ROM word read at 0x0000_0010, zero wait states, instruction = 0x0051_0113 → HSEL1 high in cycles N+1..N+2; resp_valid in N+3; resp_rdata = 0x0051_0113; resp_err = 0.
REQ-028 RAM word write at 0x1000_0004, data 0xDEAD_BEEF, hready_data low for 2 cycles → hwdata = 0xDEAD_BEEF throughout DATA; resp_valid in N+5.
REQ-029 Write to 0x0000_0008, and halfword read at 0x1000_0001 → ERR path: no HSEL; resp_valid in N+1 with resp_err = 1.
REQ-030 Read at 0x2000_0000 → decode error, resp_err = 1; next request accepted in the following cycle.
REQ-031 reset pulled low during DATA of a RAM read → all outputs reset asynchronously; no resp_valid; req_ready = 1 after release.
REQ-032 With AHB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES = 4, hready_data stuck at 0 → resp_valid with resp_err = 1 in the cycle after the 4th wait cycle.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared types and constants for the AHB data master.
// Holds the master FSM state enum, HTRANS/HSIZE encodings, the fixed HPROT
// value and the default base addresses of the instruction and data regions.
package ahb_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR,
    S_RESP
  } state_t;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;
  localparam logic [3:0] HPROT_DATA = 4'b0011;
  localparam logic [31:0] DEF_ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] DEF_RAM_BASE = 32'h1000_0000;
endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: combinational region select and legality check for a core request.
// Ports:
//   addr    in  32  byte address of the request
//   size    in  3   0 = byte, 1 = half, 2 = word; larger values are illegal
//   write   in  1   1 = store (stores to the instruction region are illegal)
//   sel_rom out 1   address lies in the instruction region
//   sel_ram out 1   address lies in the data region (never together with sel_rom)
//   illegal out 1   unmapped address, bad size, misaligned access or ROM store
module ahb_addr_decode
  import ahb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE    = DEF_ROM_BASE,
  parameter logic [31:0] RAM_BASE    = DEF_RAM_BASE,
  parameter int          REGION_BITS = 16
) (
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        write,
  output logic        sel_rom,
  output logic        sel_ram,
  output logic        illegal
);
  // Keeps only the region-number bits of an address.
  localparam logic [31:0] MASK = ~((32'd1 << REGION_BITS) - 32'd1);
  logic misaligned;
  assign sel_rom = (addr & MASK) == (ROM_BASE & MASK);
  // ROM wins if both bases ever alias, so the two selects stay exclusive.
  assign sel_ram = !sel_rom && ((addr & MASK) == (RAM_BASE & MASK));
  assign misaligned = (size == HSIZE_HALF && addr[0]) ||
                      (size == HSIZE_WORD && addr[1:0] != 2'b00);
  assign illegal = !(sel_rom || sel_ram) || size > HSIZE_WORD || misaligned ||
                   (sel_rom && write);
endmodule

// File: rtl/ahb_data_master.sv
// ahb_data_master: single-outstanding AHB master bridging a core request port to ROM/RAM slaves.
// Optional feature: define AHB_MASTER_TIMEOUT_EN to abort a data phase with an
// error after TIMEOUT_CYCLES wait states; otherwise the data phase waits forever.
// Ports:
//   clk, reset                       clock (rising edge), async active-low reset
//   req_valid/req_ready              core request handshake (ready only in IDLE)
//   req_addr, req_wdata, req_write   request address, store data, store flag
//   req_size, req_signed             access size, sign-extend-load flag
//   resp_valid, resp_rdata, resp_err one-cycle response strobe, data, error
//   HSEL1, HSEL2                     ROM / RAM slave selects
//   haddr, hwdata, hwrite, hsize     AHB address/data phase signals
//   hprot, htrans, is_signed         AHB protection, transfer type, load sign
//   instruction, load_out            ROM / RAM read data
//   hready_inst/hresp_inst           ROM handshake
//   hready_data/hresp_data           RAM handshake
module ahb_data_master
  import ahb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE       = DEF_ROM_BASE,
  parameter logic [31:0] RAM_BASE       = DEF_RAM_BASE,
  parameter int          REGION_BITS    = 16,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        HSEL1,
  output logic        HSEL2,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic        is_signed,
  input  logic [31:0] instruction,
  input  logic [31:0] load_out,
  input  logic        hready_inst,
  input  logic        hready_data,
  input  logic        hresp_inst,
  input  logic        hresp_data
);
  state_t      state, nxt;
  logic        live;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [2:0]  size_q;
  logic        write_q, signed_q, rom_q, ram_q, err_q;
  logic        sel_rom, sel_ram, illegal;
  logic        accept, hrdy, hrsp, done, tmo, act;

  ahb_addr_decode #(
    .ROM_BASE   (ROM_BASE),
    .RAM_BASE   (RAM_BASE),
    .REGION_BITS(REGION_BITS)
  ) u_decode (
    .addr   (req_addr),
    .size   (req_size),
    .write  (req_write),
    .sel_rom(sel_rom),
    .sel_ram(sel_ram),
    .illegal(illegal)
  );

  // Only the selected slave's handshake matters; the other one is ignored.
  assign hrdy   = rom_q ? hready_inst : hready_data;
  assign hrsp   = rom_q ? hresp_inst : hresp_data;
  assign accept = req_ready && req_valid;
  assign done   = state == S_DATA && hrdy;

`ifdef AHB_MASTER_TIMEOUT_EN
  logic [31:0] wait_cnt;
  // Fires on the wait cycle that brings the count up to TIMEOUT_CYCLES.
  assign tmo = state == S_DATA && !hrdy && wait_cnt == 32'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) wait_cnt <= '0;
    else if (state == S_ADDR) wait_cnt <= '0;
    else if (state == S_DATA && !hrdy) wait_cnt <= wait_cnt + 32'd1;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  nxt = accept ? (illegal ? S_ERR : S_ADDR) : S_IDLE;
      S_ADDR:  nxt = S_DATA;
      S_DATA:  nxt = (done || tmo) ? S_RESP : S_DATA;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= S_IDLE;
      live     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      rom_q    <= 1'b0;
      ram_q    <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= nxt;
      // Holds req_ready low until the first edge after reset release.
      live  <= 1'b1;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        size_q   <= req_size;
        write_q  <= req_write;
        signed_q <= req_signed;
        rom_q    <= sel_rom;
        ram_q    <= sel_ram;
      end
      if (done || tmo) begin
        rdata_q <= (tmo || write_q) ? '0 : (rom_q ? instruction : load_out);
        err_q   <= tmo || hrsp;
      end
    end

  assign act        = state == S_ADDR || state == S_DATA;
  assign req_ready  = live && state == S_IDLE;
  assign HSEL1      = act && rom_q;
  assign HSEL2      = act && ram_q;
  assign haddr      = act ? addr_q : '0;
  assign hwrite     = act && write_q;
  assign hsize      = act ? size_q : HSIZE_BYTE;
  assign is_signed  = act && signed_q;
  assign htrans     = state == S_ADDR ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hwdata     = state == S_DATA ? wdata_q : '0;
  assign hprot      = HPROT_DATA;
  assign resp_valid = state == S_RESP || state == S_ERR;
  assign resp_rdata = state == S_RESP ? rdata_q : '0;
  assign resp_err   = state == S_ERR || (state == S_RESP && err_q);
endmodule

// File: tb/tb_ahb_data_master.sv
// tb_ahb_data_master: randomized scoreboard bench for ahb_data_master against a timing/legality model.
module tb_ahb_data_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err, HSEL1, HSEL2, hwrite, is_signed;
  logic [31:0] resp_rdata, haddr, hwdata;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] instruction = '0, load_out = '0;
  logic        hready_inst = 1'b1, hready_data = 1'b1, hresp_inst = 1'b0, hresp_data = 1'b0;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 0;
`endif

  ahb_data_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .HSEL1(HSEL1), .HSEL2(HSEL2), .haddr(haddr),
    .hwdata(hwdata), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
    .htrans(htrans), .is_signed(is_signed), .instruction(instruction),
    .load_out(load_out), .hready_inst(hready_inst), .hready_data(hready_data),
    .hresp_inst(hresp_inst), .hresp_data(hresp_data)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          c;
  } exp_t;
  exp_t q[$];

  int vectors = 0, errs = 0;
  bit chk_en = 1'b0;
  int sel_lo = 0, sel_hi = -1, busy_lo = 0, busy_hi = -1, wait_lo = 0, wait_hi = -1;
  logic [31:0] cur_addr = '0, cur_wdata = '0, cur_sdata = '0;
  logic [2:0]  cur_sz = '0;
  logic        cur_wr = 1'b0, cur_sg = 1'b0, cur_rom = 1'b0, cur_hresp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_hsel1"}, HSEL1, 0);
    chk({tag, "_hsel2"}, HSEL2, 0);
    chk({tag, "_haddr"}, haddr, 0);
    chk({tag, "_hwdata"}, hwdata, 0);
    chk({tag, "_hwrite"}, hwrite, 0);
    chk({tag, "_hsize"}, hsize, 0);
    chk({tag, "_hprot"}, hprot, 4'b0011);
    chk({tag, "_htrans"}, htrans, 0);
    chk({tag, "_is_signed"}, is_signed, 0);
  endtask

  function automatic bit in_rom(input logic [31:0] a);
    return longint'(a) >= 64'h0 && longint'(a) < 64'h1_0000;
  endfunction

  function automatic bit in_ram(input logic [31:0] a);
    return longint'(a) >= 64'h1000_0000 && longint'(a) < 64'h1001_0000;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    if (!(in_rom(a) || in_ram(a)) || sz > 3'd2) return 1'b0;
    if (int'(a % (32'd1 << sz)) != 0) return 1'b0;
    return !(in_rom(a) && wr);
  endfunction

  // Slave models: the selected slave inserts the planned wait states, the other one emits noise.
  initial forever begin
    bit wt;
    @(negedge clk);
    wt = cyc >= wait_lo && cyc <= wait_hi;
    hready_inst = 1'($urandom); hready_data = 1'($urandom);
    hresp_inst = 1'($urandom); hresp_data = 1'($urandom);
    instruction = $urandom; load_out = $urandom;
    if (cur_rom) begin
      hready_inst = !wt; hresp_inst = cur_hresp; instruction = cur_sdata;
    end else begin
      hready_data = !wt; hresp_data = cur_hresp; load_out = cur_sdata;
    end
  end

  // Monitor: response scoreboard plus per-cycle bus/ready timing checks.
  initial forever begin
    exp_t e;
    bit in_sel, in_addr;
    @(negedge clk);
    if (resp_valid) begin
      if (q.size() == 0) begin
        vectors++; errs++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.c);
        chk("resp_rdata", resp_rdata, e.rd);
        chk("resp_err", resp_err, e.er);
      end
    end else if (q.size() != 0 && cyc == q[0].c) begin
      vectors++; errs++;
      $display("FAIL resp_missing: got resp_valid=0 expected 1 at cycle %0d", cyc);
    end
    if (chk_en) begin
      in_sel  = cyc >= sel_lo && cyc <= sel_hi;
      in_addr = in_sel && cyc == sel_lo;
      chk("req_ready", req_ready, !(cyc >= busy_lo && cyc <= busy_hi));
      chk("hsel1", HSEL1, in_sel && cur_rom);
      chk("hsel2", HSEL2, in_sel && !cur_rom);
      chk("htrans", htrans, in_addr ? 32'd2 : 32'd0);
      if (in_sel) begin
        chk("haddr", haddr, cur_addr);
        chk("hwrite", hwrite, cur_wr);
      end
      if (in_addr) begin
        chk("hsize", hsize, cur_sz);
        chk("is_signed", is_signed, cur_sg);
      end
      if (in_sel && !in_addr && cur_wr) chk("hwdata", hwdata, cur_wdata);
    end
  end

  task automatic issue(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                       input logic [2:0] sz, input logic sg, input int w,
                       input logic [31:0] sd, input logic hr, input bit abort);
    int a = 0, rc;
    bit acc = 1'b0, ok, timed;
    @(posedge clk); #1;
    req_addr = addr; req_wdata = wdata; req_write = wr; req_size = sz; req_signed = sg;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) begin acc = 1'b1; a = cyc; end
    end
    if (!acc) begin
      vectors++; errs++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 at cycle %0d", cyc);
      req_valid = 1'b0;
      return;
    end
    ok = legal(addr, wr, sz);
    timed = TO > 0 && w >= TO;
    cur_addr = addr; cur_wdata = wdata; cur_wr = wr; cur_sz = sz; cur_sg = sg;
    cur_sdata = sd; cur_hresp = hr; cur_rom = in_rom(addr);
    if (!ok) begin
      q.push_back('{rd: 32'h0, er: 1'b1, c: a + 1});
      sel_lo = 0; sel_hi = -1; busy_lo = a + 1; busy_hi = a + 1; wait_lo = 0; wait_hi = -1;
    end else begin
      rc = timed ? a + 2 + TO : a + 3 + w;
      q.push_back('{rd: (timed || wr) ? 32'h0 : sd, er: timed ? 1'b1 : hr, c: rc});
      sel_lo = a + 1; sel_hi = rc - 1; busy_lo = a + 1; busy_hi = rc;
      wait_lo = a + 2; wait_hi = a + 1 + w;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom; req_write = 1'($urandom);
    req_size = 3'($urandom); req_signed = 1'($urandom);
    if (abort) begin
      while (cyc < a + 3) @(negedge clk);
      #2;
      chk_en = 1'b0; q.delete();
      sel_hi = -1; busy_hi = -1; wait_hi = -1;
      reset = 1'b0;
      #1 reset_outs("midreset");
      @(negedge clk);
      reset_outs("hold");
      #2 reset = 1'b1;
      #1 chk("ready_before_edge", req_ready, 0);
      @(negedge clk);
      chk("ready_after_release", req_ready, 1);
      chk_en = 1'b1;
      return;
    end
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      vectors++; errs++;
      $display("FAIL resp_timeout: got no resp_valid expected one by cycle %0d", q[0].c);
      q.delete();
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 reset_outs("reset");
    repeat (2) @(negedge clk);
    reset_outs("reset_hold");
    #2 reset = 1'b1;
    #1 chk("ready_first", req_ready, 0);
    @(negedge clk);
    chk("ready_release", req_ready, 1);
    chk_en = 1'b1;
    issue(32'h0000_0010, 32'h0, 1'b0, 3'd2, 1'b0, 0, 32'h0051_0113, 1'b0, 1'b0);
    issue(32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 3'd2, 1'b0, 2, 32'h1234_5678, 1'b0, 1'b0);
    issue(32'h0000_0008, 32'h5555_AAAA, 1'b1, 3'd2, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    issue(32'h1000_0001, 32'h0, 1'b0, 3'd1, 1'b1, 0, 32'h0, 1'b0, 1'b0);
    issue(32'h2000_0000, 32'h0, 1'b0, 3'd2, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    issue(32'h1000_0103, 32'h0, 1'b0, 3'd0, 1'b1, 1, 32'h0000_0080, 1'b1, 1'b0);
    issue(32'h1000_0008, 32'h0, 1'b0, 3'd3, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    issue(32'h1000_0020, 32'h0, 1'b0, 3'd2, 1'b0, 10, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue(32'h1000_0040, 32'h0, 1'b0, 3'd2, 1'b0, 6, 32'h0BAD_CAFE, 1'b0, 1'b0);
    for (int n = 0; n < 150; n++) begin
      int r;
      logic [31:0] addr;
      logic [2:0] sz;
      r = $urandom_range(0, 5);
      addr = r < 2 ? 32'($urandom_range(0, 65535)) :
             r < 4 ? 32'h1000_0000 | 32'($urandom_range(0, 65535)) : $urandom;
      sz = $urandom_range(0, 9) > 8 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0 && sz <= 3'd2) addr = addr & ~((32'd1 << sz) - 32'd1);
      issue(addr, $urandom, 1'($urandom), sz, 1'($urandom), $urandom_range(0, 6),
            $urandom, $urandom_range(0, 4) == 0, 1'b0);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected completion by time 2000000");
    $fatal(1, "watchdog");
  end
endmodule
